// File: rtl/videomem_fill.sv
// videomem_fill: frame-buffer fill engine on the SDRAM controller write port.
// Checkerboard pattern for mode 3 is built only with VIDEOMEM_FILL_CHECKER_EN.
module videomem_fill #(
  parameter int ADDR_W          = 25,
  parameter int DATA_W          = 32,
  parameter int BURST_LEN       = 4,
  parameter int NUM_HORZ_WR_REQ = 24,
  parameter int NUM_WR_LINES    = 720,
  parameter bit AUTO_START      = 1'b1
) (
  input  logic              mem_clock,
  input  logic              reset,
  input  logic              mem_ready,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [15:0]       fill_color,
  input  logic              mem_req_ack,
  input  logic              give_next_data,
  output logic              wr_request,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              complete
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 0;
  localparam int BT_W   = (BEAT_W > 0) ? BEAT_W : 1;
  localparam int NR_W   = (NUM_HORZ_WR_REQ > 1) ?
                          $clog2(NUM_HORZ_WR_REQ) : 1;
  localparam int NL_W   = (NUM_WR_LINES > 1) ?
                          $clog2(NUM_WR_LINES) : 1;
  localparam int FA_W   = NL_W + NR_W + BEAT_W;
  localparam int XW     = NR_W + BT_W;
  localparam int PIX_N  = DATA_W / 16;
  localparam int ARM_LEN = 4;

  typedef enum logic [2:0] {
    IDLE, ARM, REQ, DATA, DONE
  } state_t;

  state_t          state, state_nx;
  logic [1:0]      arm_cnt, arm_cnt_nx;
  logic [NR_W-1:0] nreq, nreq_nx;
  logic [NL_W-1:0] nline, nline_nx;
  logic [BT_W-1:0] beat, beat_nx;
  logic [1:0]      mode_q, mode_nx;
  logic [15:0]     color_q, color_nx;
  logic            rdy_seen;
  logic            launch;
  logic            last_beat, last_req, last_line;
  logic            req_nx, busy_nx, cmpl_nx;

  assign last_beat = (beat == BT_W'(BURST_LEN - 1));
  assign last_req  = (nreq == NR_W'(NUM_HORZ_WR_REQ - 1));
  assign last_line = (nline == NL_W'(NUM_WR_LINES - 1));

  // auto launch fires once per observed rise of mem_ready
  assign launch = mem_ready &&
                  ((start && (state == IDLE || state == DONE)) ||
                   (AUTO_START && !rdy_seen));

  always_comb begin
    state_nx   = state;
    arm_cnt_nx = arm_cnt;
    nreq_nx    = nreq;
    nline_nx   = nline;
    beat_nx    = beat;
    mode_nx    = mode_q;
    color_nx   = color_q;
    if (!mem_ready) begin
      state_nx = IDLE;
    end else if (launch) begin
      state_nx   = ARM;
      arm_cnt_nx = '0;
      nreq_nx    = '0;
      nline_nx   = '0;
      beat_nx    = '0;
      mode_nx    = mode;
      color_nx   = fill_color;
    end else begin
      unique case (state)
        ARM: begin
          if (arm_cnt == 2'(ARM_LEN - 1)) state_nx = REQ;
          else arm_cnt_nx = arm_cnt + 2'd1;
        end
        REQ: begin
          if (wr_request && mem_req_ack) begin
            state_nx = DATA;
            beat_nx  = '0;
          end
        end
        DATA: begin
          if (give_next_data) begin
            if (last_beat) begin
              beat_nx  = '0;
              state_nx = REQ;
              if (last_req) begin
                nreq_nx = '0;
                if (last_line) begin
                  nline_nx = '0;
                  state_nx = DONE;
                end else begin
                  nline_nx = nline + 1'b1;
                end
              end else begin
                nreq_nx = nreq + 1'b1;
              end
            end else begin
              beat_nx = beat + 1'b1;
            end
          end
        end
        IDLE, DONE: ;
        default: state_nx = IDLE;
      endcase
    end
  end

  assign req_nx  = (state == REQ) && (state_nx == REQ);
  assign busy_nx = (state_nx == ARM) || (state_nx == REQ) ||
                   (state_nx == DATA);
  assign cmpl_nx = (state_nx == DONE);

  always_ff @(posedge mem_clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      arm_cnt    <= '0;
      nreq       <= '0;
      nline      <= '0;
      beat       <= '0;
      mode_q     <= '0;
      color_q    <= '0;
      rdy_seen   <= 1'b0;
      wr_request <= 1'b0;
      busy       <= 1'b0;
      complete   <= 1'b0;
    end else begin
      state      <= state_nx;
      arm_cnt    <= arm_cnt_nx;
      nreq       <= nreq_nx;
      nline      <= nline_nx;
      beat       <= beat_nx;
      mode_q     <= mode_nx;
      color_q    <= color_nx;
      rdy_seen   <= mem_ready;
      wr_request <= req_nx;
      busy       <= busy_nx;
      complete   <= cmpl_nx;
    end
  end

  logic [FA_W-1:0] addr_full;
  logic [7:0]      x;
  logic [4:0]      y;
  logic [15:0]     pix;
  logic            all_ones;

  assign addr_full = FA_W'({nline, nreq}) << BEAT_W;
  assign wr_addr   = ADDR_W'(addr_full);
  assign x = 8'((XW'(nreq) << BEAT_W) | XW'(beat));
  assign y = 5'(nline);

  always_comb begin
    pix      = color_q;
    all_ones = 1'b0;
    unique case (mode_q)
      2'd0: pix = color_q;
      2'd1: begin
        if (x[7:5] == 3'd0) all_ones = 1'b1;
        else pix = {x[7] ? x[4:0] : 5'd0,
                    x[6] ? {x[4:0], 1'b0} : 6'd0,
                    x[5] ? x[4:0] : 5'd0};
      end
      2'd2: pix = {y, x[5:0], x[4:0]};
      2'd3: begin
`ifdef VIDEOMEM_FILL_CHECKER_EN
        pix = (x[3] ^ y[3]) ? color_q : 16'h0000;
`else
        pix = color_q;
`endif
      end
      default: pix = color_q;
    endcase
  end

  assign wr_data = all_ones ? {DATA_W{1'b1}} : {PIX_N{pix}};

endmodule

// File: tb/tb_videomem_fill.sv
// Bench for videomem_fill: controller model, beat scoreboard and
// directed control checks.
`timescale 1ns/1ps
module tb_videomem_fill;

  localparam int AW = 25;
  localparam int DW = 32;
  localparam int BL = 4;
  localparam int NH = 66;
  localparam int NL = 9;

  logic          mem_clock = 1'b0;
  logic          reset;
  logic          mem_ready;
  logic          start;
  logic [1:0]    mode;
  logic [15:0]   fill_color;
  logic          mem_req_ack;
  logic          give_next_data;
  logic          wr_request;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          complete;

  logic ack_ctl = 1'b0;
  logic gnd_ctl = 1'b0;
  logic stray_ack = 1'b0;
  logic stray_gnd = 1'b0;

  assign mem_req_ack    = ack_ctl | stray_ack;
  assign give_next_data = gnd_ctl | stray_gnd;

  videomem_fill #(
    .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL),
    .NUM_HORZ_WR_REQ(NH), .NUM_WR_LINES(NL),
    .AUTO_START(1'b1)
  ) dut (
    .mem_clock(mem_clock), .reset(reset),
    .mem_ready(mem_ready), .start(start),
    .mode(mode), .fill_color(fill_color),
    .mem_req_ack(mem_req_ack),
    .give_next_data(give_next_data),
    .wr_request(wr_request), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy),
    .complete(complete)
  );

  always #5 mem_clock = ~mem_clock;

  typedef struct {
    int            idx;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   strobe_no = 0;
  int   cur_idx = 0;
  int   beats_left = 0;
  bit   hold_ack = 1'b0;
  bit   gap_en = 1'b0;
  bit   gap_tog = 1'b0;

  task automatic push(input int idx, input int addr,
                      input logic [DW-1:0] data);
    exp_t e;
    e.idx  = idx;
    e.addr = AW'(addr);
    e.data = data;
    sbq.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge mem_clock);
    #1;
  endtask

  task automatic wait_for(input string nm, input bit sel,
                          input int budget);
    int i;
    i = 0;
    while (!(sel ? complete : wr_request) && i < budget) begin
      tick();
      i++;
    end
    chk(nm, (i < budget), 1'b1);
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int i;
    i = 0;
    while (strobe_no < n && i < budget) begin
      tick();
      i++;
    end
    chk("strobe_wait", (i < budget), 1'b1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge mem_clock);
      gnd_ctl = 1'b0;
      if (!busy) begin
        ack_ctl    = 1'b0;
        beats_left = 0;
        strobe_no  = 0;
      end else begin
        if (ack_ctl) begin
          ack_ctl    = 1'b0;
          beats_left = BL;
        end else if (wr_request && !hold_ack && beats_left == 0) begin
          ack_ctl = 1'b1;
        end
        if (beats_left > 0) begin
          gap_tog = !gap_tog;
          if (!gap_en || gap_tog) begin
            gnd_ctl = 1'b1;
            cur_idx = strobe_no;
            strobe_no++;
            beats_left--;
          end
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge mem_clock);
      #1;
      if (gnd_ctl && sbq.size() > 0 && sbq[0].idx == cur_idx) begin
        e = sbq.pop_front();
        n_chk++;
        if (wr_addr !== e.addr || wr_data !== e.data) begin
          n_fail++;
          $display("FAIL beat %0d: addr %0d data %h, required addr %0d data %h",
                   e.idx, wr_addr, wr_data, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset = 1'b1;
    mem_ready = 1'b0;
    start = 1'b0;
    mode = 2'd1;
    fill_color = 16'h1234;
    repeat (3) tick();
    chk("rst_req", wr_request, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmpl", complete, 1'b0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 32'h0);
    reset = 1'b0;
    tick();

    push(0, 0, 32'hFFFFFFFF);
    push(32, 32, 32'h00000000);
    push(40, 40, 32'h00080008);
    push(165, 164, 32'h28052805);
    push(255, 252, 32'hFFDFFFDF);
    push(256, 256, 32'hFFFFFFFF);
    push(264, 512, 32'hFFFFFFFF);
    push(2375, 4356, 32'hFFFFFFFF);
    mem_ready = 1'b1;
    tick();
    chk("busy_after_launch", busy, 1'b1);
    chk("req_low_in_arm", wr_request, 1'b0);
    lat = 0;
    while (!wr_request && lat < 10) begin
      tick();
      lat++;
    end
    chk("req_latency", lat, 5);
    chk("first_addr", wr_addr, 0);
    wait_for("bars_done", 1'b1, 8000);
    chk("bars_cmpl", complete, 1'b1);
    chk("bars_busy", busy, 1'b0);
    chk("bars_req", wr_request, 1'b0);

    mode = 2'd0;
    fill_color = 16'hF800;
    push(0, 0, 32'hF800F800);
    push(1, 0, 32'hF800F800);
    push(5, 4, 32'hF800F800);
    push(300, 548, 32'hF800F800);
    push(2375, 4356, 32'hF800F800);
    pulse_start();
    chk("restart_cmpl", complete, 1'b0);
    chk("restart_busy", busy, 1'b1);
    wait_strobes(100, 2000);
    fill_color = 16'h001F;
    mode = 2'd1;
    wait_strobes(150, 2000);
    pulse_start();
    wait_for("solid_done", 1'b1, 8000);
    chk("solid_cmpl", complete, 1'b1);

    mode = 2'd2;
    hold_ack = 1'b1;
    gap_en = 1'b1;
    push(0, 0, 32'h00000000);
    push(1, 0, 32'h00210021);
    push(37, 36, 32'h04A504A5);
    push(334, 580, 32'h08C608C6);
    push(2157, 4140, 32'h45AD45AD);
    pulse_start();
    stray_ack = 1'b1;
    repeat (2) tick();
    stray_ack = 1'b0;
    wait_for("grad_req", 1'b0, 20);
    chk("stray_addr0", wr_addr, 0);
    stray_gnd = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    stray_gnd = 1'b0;
    tick();
    chk("stray_req_held", wr_request, 1'b1);
    chk("stray_addr_held", wr_addr, 0);
    chk("stray_busy", busy, 1'b1);
    hold_ack = 1'b0;
    wait_for("grad_done", 1'b1, 12000);
    chk("grad_cmpl", complete, 1'b1);
    gap_en = 1'b0;

    mode = 2'd3;
    fill_color = 16'h07E0;
`ifdef VIDEOMEM_FILL_CHECKER_EN
    push(0, 0, 32'h00000000);
    push(8, 8, 32'h07E007E0);
    push(2112, 4096, 32'h07E007E0);
    push(2120, 4104, 32'h00000000);
`else
    push(0, 0, 32'h07E007E0);
    push(8, 8, 32'h07E007E0);
    push(2112, 4096, 32'h07E007E0);
    push(2120, 4104, 32'h07E007E0);
`endif
    pulse_start();
    wait_for("chk_done", 1'b1, 8000);
    chk("chk_cmpl", complete, 1'b1);

    mode = 2'd0;
    fill_color = 16'h1234;
    push(0, 0, 32'h12341234);
    push(5, 4, 32'h12341234);
    pulse_start();
    wait_strobes(6, 200);
    chk("abort_pt_addr", wr_addr, 4);
    mem_ready = 1'b0;
    tick();
    chk("abort_req", wr_request, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_cmpl", complete, 1'b0);
    pulse_start();
    repeat (2) tick();
    chk("no_launch_low", busy, 1'b0);
    fill_color = 16'hABCD;
    push(0, 0, 32'hABCDABCD);
    push(3, 0, 32'hABCDABCD);
    push(4, 4, 32'hABCDABCD);
    mem_ready = 1'b1;
    tick();
    chk("auto_relaunch", busy, 1'b1);
    wait_for("relaunch_req", 1'b0, 20);
    chk("relaunch_addr", wr_addr, 0);
    wait_for("relaunch_done", 1'b1, 8000);
    chk("relaunch_cmpl", complete, 1'b1);

    repeat (4) tick();
    chk("sb_drain", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
